id_stage: RTL

Instruction-decode stage of the five-stage RISC-V core. Sits between the IF/ID latch and EX: drives `regfile` read addresses from the fetched instruction, resolves operands (x0 masking, forwarding, WB write-through), generates the immediate, detects load-use hazards, and registers everything into the ID/EX pipeline register with stall and flush control.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/imm_gen.sv | 27 ++
 rtl/id_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode constants, immediate-type enum and decode helpers
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_type_of = IMM_I;
      OPC_STORE:                      imm_type_of = IMM_S;
      OPC_BRANCH:                     imm_type_of = IMM_B;
      OPC_LUI, OPC_AUIPC:             imm_type_of = IMM_U;
      OPC_JAL:                        imm_type_of = IMM_J;
      default:                        imm_type_of = IMM_NONE;
    endcase
  endfunction

  function automatic logic opcode_legal(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: opcode_legal = 1'b1;
      default:                                opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational instruction to sign-extended immediate
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type_of(instr[6:0]))
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage with operand resolution, hazard detection and ID/EX register
// Define ID_FORWARD_EN for EX/MEM forwarding; otherwise any EX/MEM producer match stalls.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      ex_rd_addr,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic [XLEN-1:0] ex_result,
  input  logic [4:0]      mem_rd_addr,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [4:0]      wb_rd_addr,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [31:0]     id_ex_instr,
  output logic [XLEN-1:0] id_ex_rs1_val,
  output logic [XLEN-1:0] id_ex_rs2_val,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rd_addr,
  output logic            id_ex_illegal
);

  logic [6:0]      opcode;
  logic            legal, rs1_used, rs2_used, hazard, capture;
  logic            ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic [XLEN-1:0] rs1_val, rs2_val, imm;

  assign opcode   = if_instr[6:0];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];
  assign legal    = opcode_legal(opcode);
  assign rs1_used = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  assign rs2_used = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);

  // A producer targeting x0 never matches, which keeps x0 masking intact
  assign ex_hit1  = rs1_used && ex_reg_write  && ex_rd_addr  != 5'd0 && ex_rd_addr  == rs1_addr;
  assign ex_hit2  = rs2_used && ex_reg_write  && ex_rd_addr  != 5'd0 && ex_rd_addr  == rs2_addr;
  assign mem_hit1 = rs1_used && mem_reg_write && mem_rd_addr != 5'd0 && mem_rd_addr == rs1_addr;
  assign mem_hit2 = rs2_used && mem_reg_write && mem_rd_addr != 5'd0 && mem_rd_addr == rs2_addr;
  assign wb_hit1  = wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == rs1_addr;
  assign wb_hit2  = wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == rs2_addr;

  always_comb begin
    rs1_val = rs1_data;
    if (rs1_addr == 5'd0) rs1_val = '0;
`ifdef ID_FORWARD_EN
    else if (ex_hit1)     rs1_val = ex_result;
    else if (mem_hit1)    rs1_val = mem_result;
`endif
    else if (wb_hit1)     rs1_val = wb_data;
  end

  always_comb begin
    rs2_val = rs2_data;
    if (rs2_addr == 5'd0) rs2_val = '0;
`ifdef ID_FORWARD_EN
    else if (ex_hit2)     rs2_val = ex_result;
    else if (mem_hit2)    rs2_val = mem_result;
`endif
    else if (wb_hit2)     rs2_val = wb_data;
  end

`ifdef ID_FORWARD_EN
  assign hazard = ex_mem_read && (ex_hit1 || ex_hit2);
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_result, mem_result, ex_mem_read};
  assign hazard = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
`endif

  // Flush wins so IF can take the redirected fetch this cycle
  assign stall   = if_valid && hazard && !flush;
  assign capture = if_valid && !hazard && !flush;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_instr),
    .imm   (imm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_valid   <= 1'b0;
      id_ex_pc      <= '0;
      id_ex_instr   <= '0;
      id_ex_rs1_val <= '0;
      id_ex_rs2_val <= '0;
      id_ex_imm     <= '0;
      id_ex_rd_addr <= '0;
      id_ex_illegal <= 1'b0;
    end else begin
      id_ex_valid   <= capture;
      id_ex_pc      <= capture ? if_pc : '0;
      id_ex_instr   <= capture ? if_instr : '0;
      id_ex_rs1_val <= capture ? rs1_val : '0;
      id_ex_rs2_val <= capture ? rs2_val : '0;
      id_ex_imm     <= capture ? imm : '0;
      id_ex_rd_addr <= capture ? if_instr[11:7] : 5'd0;
      id_ex_illegal <= capture && !legal;
    end
  end

endmodule
